// File: rtl/branch_target_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch target predictor.
// The predictor sits on the slave side; the pipeline drives the master side.
interface branch_target_predictor_if;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;

  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output stall,
    output resolve_valid,
    output resolve_pc,
    output resolve_taken,
    output resolve_target,
    output resolve_pred_taken,
    output resolve_pred_target,
    input  pc,
    input  pred_taken,
    input  pred_target,
    input  mispredict,
    input  branch_count,
    input  mispredict_count
  );

  modport slave (
    input  stall,
    input  resolve_valid,
    input  resolve_pc,
    input  resolve_taken,
    input  resolve_target,
    input  resolve_pred_taken,
    input  resolve_pred_target,
    output pc,
    output pred_taken,
    output pred_target,
    output mispredict,
    output branch_count,
    output mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Fetch-stage next-PC generator: direct-mapped BTB with 2-bit saturating counters,
// owns the fetch PC and flags mispredicts resolved in execute.
module branch_target_predictor #(
  parameter int unsigned ENTRIES      = 16,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
  input  logic                      clk,
  input  logic                      rst,
  branch_target_predictor_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      branch_count_q, branch_count_d;
  logic [31:0]      mispredict_count_q, mispredict_count_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;
  logic             lkp_hit;
  logic [31:0]      pc_plus4;
  logic             pred_taken;
  logic [31:0]      pred_target;

  logic             mispredict;

  logic [29:0]      upd_word;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr_old;
  logic             wr_en;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  // Lookup on the registered PC; always sees pre-update BTB contents.
  always_comb begin
    lkp_idx     = pc_q[IDX_W+1:2];
    lkp_tag     = pc_q[31:IDX_W+2];
    lkp_hit     = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    pc_plus4    = pc_q + 32'd4;
    pred_taken  = lkp_hit && ctr_q[lkp_idx][1];
    pred_target = lkp_hit ? target_q[lkp_idx] : pc_plus4;
  end

  always_comb begin
    mispredict = bus.resolve_valid &&
                 ((bus.resolve_taken != bus.resolve_pred_taken) ||
                  (bus.resolve_taken && (bus.resolve_target != bus.resolve_pred_target)));
  end

  always_comb begin
    if (mispredict) begin
      pc_d = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd8;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // Entries are keyed on the delay-slot PC, i.e. the branch word address + 1.
  always_comb begin
    upd_word    = bus.resolve_pc[31:2] + 30'd1;
    upd_idx     = upd_word[IDX_W-1:0];
    upd_tag     = upd_word[29:IDX_W];
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_old = ctr_q[upd_idx];
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[upd_idx];
    wr_ctr    = upd_ctr_old;
    if (bus.resolve_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.resolve_taken) begin
          wr_target = bus.resolve_target;
          wr_ctr    = (upd_ctr_old == 2'b11) ? upd_ctr_old : upd_ctr_old + 2'd1;
        end else begin
          wr_ctr    = (upd_ctr_old == 2'b00) ? upd_ctr_old : upd_ctr_old - 2'd1;
        end
      end else if (bus.resolve_taken) begin
        wr_en     = 1'b1;
        wr_target = bus.resolve_target;
        wr_ctr    = 2'b10;
      end
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q + {31'd0, bus.resolve_valid};
    mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      valid_q            <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= COUNTER_INIT;
      end
    end else begin
      pc_q               <= pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      if (wr_en) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= wr_ctr;
      end
    end
  end

  // Tag/target payload needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= wr_target;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pred_taken       = pred_taken;
  assign bus.pred_target      = pred_target;
  assign bus.mispredict       = mispredict;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed, table-driven bench for branch_target_predictor (ENTRIES=16, RESET_PC=0).
module tb_branch_target_predictor;

  logic clk;
  logic rst;

  branch_target_predictor_if bus ();

  branch_target_predictor #(
    .ENTRIES      (16),
    .RESET_PC     (32'h0000_0000),
    .COUNTER_INIT (2'b01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        misp;
    logic [31:0] bc;
    logic [31:0] mc;
  } vec_t;

  vec_t vq[$];
  int total;
  int bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtgt,
                       input logic rpt, input logic [31:0] rptgt);
    bus.stall               = st;
    bus.resolve_valid       = rv;
    bus.resolve_pc          = rpc;
    bus.resolve_taken       = rt;
    bus.resolve_target      = rtgt;
    bus.resolve_pred_taken  = rpt;
    bus.resolve_pred_target = rptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Fields: stall rv rpc rt rtgt rpt rptgt | pc pt ptgt misp bc mc (pre-edge values)
  initial begin
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h00, 0, 'h04, 0,  0, 0});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h04, 0, 'h08, 0,  0, 0});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h08, 0, 'h0C, 0,  0, 0});
    vq.push_back(vec_t'{0, 1, 'h10, 1, 'h40, 0, 'h00,  'h0C, 0, 'h10, 1,  0, 0});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h40, 0, 'h44, 0,  1, 1});
    vq.push_back(vec_t'{0, 1, 'h0C, 0, 'h00, 1, 'h99,  'h44, 0, 'h48, 1,  1, 1});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h14, 1, 'h40, 0,  2, 2});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h40, 0, 'h44, 0,  2, 2});
    vq.push_back(vec_t'{0, 1, 'h10, 1, 'h40, 1, 'h40,  'h44, 0, 'h48, 0,  2, 2});
    vq.push_back(vec_t'{0, 1, 'h10, 1, 'h40, 1, 'h40,  'h48, 0, 'h4C, 0,  3, 2});
    vq.push_back(vec_t'{1, 1, 'h10, 0, 'h00, 1, 'h40,  'h4C, 0, 'h50, 1,  4, 2});
    vq.push_back(vec_t'{1, 0, 'h00, 0, 'h00, 0, 'h00,  'h18, 0, 'h1C, 0,  5, 3});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h18, 0, 'h1C, 0,  5, 3});
    vq.push_back(vec_t'{0, 1, 'h0C, 0, 'h00, 1, 'h00,  'h1C, 0, 'h20, 1,  5, 3});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h14, 1, 'h40, 0,  6, 4});
    vq.push_back(vec_t'{0, 1, 'h10, 0, 'h00, 0, 'h00,  'h40, 0, 'h44, 0,  6, 4});
    vq.push_back(vec_t'{0, 1, 'h0C, 0, 'h00, 1, 'h00,  'h44, 0, 'h48, 1,  7, 4});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h14, 0, 'h40, 0,  8, 5});
    vq.push_back(vec_t'{0, 1, 'h50, 1, 'h14, 0, 'h00,  'h18, 0, 'h1C, 1,  8, 5});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h14, 0, 'h18, 0,  9, 6});
    vq.push_back(vec_t'{0, 1, 'h4C, 0, 'h00, 1, 'h00,  'h18, 0, 'h1C, 1,  9, 6});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h54, 1, 'h14, 0, 10, 7});
    vq.push_back(vec_t'{0, 1, 'h10, 1, 'h40, 1, 'h40,  'h14, 0, 'h18, 0, 10, 7});
    vq.push_back(vec_t'{0, 1, 'h0C, 0, 'h00, 1, 'h00,  'h18, 0, 'h1C, 1, 11, 7});
    vq.push_back(vec_t'{0, 1, 'h10, 0, 'h00, 0, 'h00,  'h14, 1, 'h40, 0, 12, 8});
    vq.push_back(vec_t'{0, 1, 'h0C, 0, 'h00, 1, 'h00,  'h40, 0, 'h44, 1, 13, 8});
    vq.push_back(vec_t'{0, 0, 'h00, 0, 'h00, 0, 'h00,  'h14, 0, 'h40, 0, 14, 9});
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_bc", bus.branch_count, 32'h0);
    chk("reset_mc", bus.mispredict_count, 32'h0);

    foreach (vq[i]) begin
      if (i != 0) @(negedge clk);
      drive(vq[i].stall, vq[i].rv, vq[i].rpc, vq[i].rt, vq[i].rtgt, vq[i].rpt, vq[i].rptgt);
      #1;
      chk($sformatf("v%0d_pc", i), bus.pc, vq[i].pc);
      chk($sformatf("v%0d_pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, vq[i].pt});
      chk($sformatf("v%0d_pred_target", i), bus.pred_target, vq[i].ptgt);
      chk($sformatf("v%0d_mispredict", i), {31'd0, bus.mispredict}, {31'd0, vq[i].misp});
      chk($sformatf("v%0d_branch_count", i), bus.branch_count, vq[i].bc);
      chk($sformatf("v%0d_mispredict_count", i), bus.mispredict_count, vq[i].mc);
    end

    // PC increment wraps from 0xFFFF_FFFC to 0.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h100, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    #1;
    chk("wrap_redirect_misp", {31'd0, bus.mispredict}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("wrap_pc_top", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_pred_target", bus.pred_target, 32'h0);
    @(negedge clk);
    #1;
    chk("wrap_pc_zero", bus.pc, 32'h0);

    // Reset mid-run with a concurrent resolve: everything cleared, resolve ignored.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("midrst_pc", bus.pc, 32'h0);
    chk("midrst_bc", bus.branch_count, 32'h0);
    chk("midrst_mc", bus.mispredict_count, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h0C, 1'b0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("midrst_fetch_pc", bus.pc, 32'h14);
    chk("midrst_btb_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("midrst_btb_ptgt", bus.pred_target, 32'h18);
    chk("midrst_bc_after", bus.branch_count, 32'd1);
    chk("midrst_mc_after", bus.mispredict_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
